// File: rtl/m_prog_loader_pkg.sv
// Shared definitions for the boot-time program loader:
// FSM state encodings for the loader and its UART receiver.
package loader_defs;

    typedef enum logic [2:0] {
        ST_HDR_LO,
        ST_HDR_HI,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/m_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_valid / frame_err pulses after the stop-bit sample.
module m_uart_rx
    import loader_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic       w_clk,
    input  logic       w_rst_n,
    input  logic       w_rxd,
    output logic       byte_valid,
    output logic       frame_err,
    output logic [7:0] rx_byte
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_e        state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             rxd_s, rxd_prev;

    // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detect
    assign rxd_s    = sync_q[1];
    assign rxd_prev = sync_q[2];

    always_comb begin
        sync_d  = {sync_q[1:0], w_rxd};
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_prev && !rxd_s) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = rxd_s;
                    ferr_d  = !rxd_s;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= RX_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;
    assign rx_byte    = shift_q;

endmodule

// File: rtl/m_prog_loader.sv
// Boot-time program loader: receives a length-prefixed image over UART and
// writes little-endian 32-bit words to memory from address 0, then enables the core.
module m_prog_loader
    import loader_defs::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rxd,
    output logic              w_we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [31:0]       w_din,
    output logic              w_ce,
    output logic              w_busy,
    output logic              w_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_byte;

    m_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .w_clk     (w_clk),
        .w_rst_n   (w_rst_n),
        .w_rxd     (w_rxd),
        .byte_valid(rx_valid),
        .frame_err (rx_ferr),
        .rx_byte   (rx_byte)
    );

    ld_state_e         state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       n_new;

    assign n_new = {rx_byte, n_q[7:0]};

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        word_d  = word_q;
        addr_d  = addr_q;
        if (rx_ferr && state_q != ST_DONE && state_q != ST_ERR) begin
            state_d = ST_ERR;
        end else begin
            case (state_q)
                ST_HDR_LO: begin
                    if (rx_valid) begin
                        n_d[7:0] = rx_byte;
                        state_d  = ST_HDR_HI;
                    end
                end
                ST_HDR_HI: begin
                    if (rx_valid) begin
                        n_d[15:8] = rx_byte;
                        if (n_new == '0) begin
                            state_d = ST_DONE;
                        end else if (32'(n_new) > DEPTH) begin
                            state_d = ST_ERR;
                        end else begin
                            wcnt_d  = '0;
                            idx_d   = '0;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        word_d[{idx_q, 3'b000} +: 8] = rx_byte;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == 2'd3) begin
                            addr_d  = wcnt_q[ADDR_W-1:0];
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    wcnt_d  = wcnt_q + 1'b1;
                    state_d = (32'(wcnt_d) == 32'(n_q)) ? ST_DONE : ST_DATA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= ST_HDR_LO;
            n_q     <= '0;
            wcnt_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
        end
    end

    // addr_q is loaded only on entry to WRITE so the last address is held between writes
    assign w_we   = (state_q == ST_WRITE);
    assign w_addr = addr_q;
    assign w_din  = word_q;
    assign w_ce   = (state_q == ST_DONE);
    assign w_err  = (state_q == ST_ERR);
    assign w_busy = (state_q == ST_HDR_HI) || (state_q == ST_DATA) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_m_prog_loader.sv
// Scoreboard bench for m_prog_loader: images are serialized onto w_rxd and a
// monitor compares every write against expectations queued by a reference model.
module tb_m_prog_loader;

    localparam int unsigned CPB   = 4;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          w_clk   = 1'b0;
    logic          w_rst_n = 1'b0;
    logic          w_rxd   = 1'b1;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_din;
    logic          w_ce;
    logic          w_busy;
    logic          w_err;

    m_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .w_clk  (w_clk),
        .w_rst_n(w_rst_n),
        .w_rxd  (w_rxd),
        .w_we   (w_we),
        .w_addr (w_addr),
        .w_din  (w_din),
        .w_ce   (w_ce),
        .w_busy (w_busy),
        .w_err  (w_err)
    );

    always #5 w_clk = ~w_clk;

    int unsigned    n_cmp = 0;
    int unsigned    n_bad = 0;
    logic [AW+31:0] sb_q[$];
    logic [AW+31:0] sb_e;
    logic [31:0]    img[0:31];
    bit             exp_ce_after_last = 1'b0;
    bit             ce_check_pending  = 1'b0;
    bit             hold_check        = 1'b0;
    logic [AW-1:0]  hold_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard
    always @(negedge w_clk) begin
        if (ce_check_pending) begin
            check("ce_after_last_write", 64'(w_ce), 64'd1);
            check("busy_after_last_write", 64'(w_busy), 64'd0);
            ce_check_pending = 1'b0;
        end
        if (hold_check) begin
            check("addr_hold", 64'(w_addr), 64'(hold_addr));
            hold_check = 1'b0;
        end
        if (w_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_write", 64'd1, 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("write_addr", 64'(w_addr), 64'(sb_e[AW+31:32]));
                check("write_data", 64'(w_din), 64'(sb_e[31:0]));
                if (sb_q.size() == 0 && exp_ce_after_last) ce_check_pending = 1'b1;
            end
            hold_check = 1'b1;
            hold_addr  = w_addr;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge w_clk);
        w_rxd = 1'b0;
        repeat (CPB) @(negedge w_clk);
        for (int i = 0; i < 8; i++) begin
            w_rxd = b[i];
            repeat (CPB) @(negedge w_clk);
        end
        w_rxd = stop_bit;
        repeat (CPB) @(negedge w_clk);
        w_rxd = 1'b1;
        repeat ($urandom_range(0, 2)) @(negedge w_clk);
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        w_rst_n = 1'b0;
        repeat (3) @(negedge w_clk);
        w_rst_n = 1'b1;
        repeat (2) @(negedge w_clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},   64'(w_we),   64'd0);
        check({tag, "_addr"}, 64'(w_addr), 64'd0);
        check({tag, "_din"},  64'(w_din),  64'd0);
        check({tag, "_ce"},   64'(w_ce),   64'd0);
        check({tag, "_busy"}, 64'(w_busy), 64'd0);
        check({tag, "_err"},  64'(w_err),  64'd0);
    endtask

    task automatic wait_outcome();
        int unsigned k;
        k = 0;
        while (!(w_ce || w_err) && k < 2000) begin
            @(negedge w_clk);
            k++;
        end
        if (!(w_ce || w_err)) check("outcome_timeout", 64'd0, 64'd1);
        repeat (4) @(negedge w_clk);
    endtask

    // Reference model: a count of 1..DEPTH writes img[i] at address i then runs;
    // zero just runs; anything larger is an error with no writes.
    task automatic run_load(input int unsigned n);
        logic [15:0] nn;
        logic [31:0] w;
        int unsigned nsend;
        bit          ok;
        do_reset();
        nn = 16'(n);
        ok = (n <= DEPTH);
        exp_ce_after_last = (n > 0) && ok;
        if (n > 0 && ok)
            for (int unsigned i = 0; i < n; i++) sb_q.push_back({AW'(i), img[i]});
        send_byte(nn[7:0], 1'b1);
        send_byte(nn[15:8], 1'b1);
        nsend = ok ? n : 2;
        for (int unsigned i = 0; i < nsend; i++) begin
            w = img[i];
            for (int unsigned j = 0; j < 4; j++) send_byte(w[8*j +: 8], 1'b1);
        end
        wait_outcome();
        check("final_ce",   64'(w_ce),   64'(ok));
        check("final_err",  64'(w_err),  64'(!ok));
        check("final_busy", 64'(w_busy), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge w_clk);
        check_idle_outputs("reset");
        do_reset();
        check_idle_outputs("post_reset");

        // Normal 2-word load
        img[0] = 32'h0000_0013;
        img[1] = 32'h000F_0033;
        run_load(2);

        // Empty image
        run_load(0);

        // Oversize headers, including one past full depth
        run_load(4097);
        run_load(DEPTH + 1);

        // Full depth
        for (int unsigned i = 0; i < DEPTH; i++) img[i] = i;
        run_load(DEPTH);

        // Framing error after one data byte
        do_reset();
        exp_ce_after_last = 1'b0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h5C, 1'b0);
        wait_outcome();
        check("ferr_err",  64'(w_err),  64'd1);
        check("ferr_ce",   64'(w_ce),   64'd0);
        check("ferr_busy", 64'(w_busy), 64'd0);

        // Glitch, then reset in the middle of a 1-word image
        do_reset();
        @(negedge w_clk);
        w_rxd = 1'b0;
        @(negedge w_clk);
        w_rxd = 1'b1;
        repeat (20 * CPB) @(negedge w_clk);
        check("glitch_busy", 64'(w_busy), 64'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        check("mid_busy", 64'(w_busy), 64'd1);
        @(negedge w_clk);
        w_rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        img[0] = 32'h1234_5678;
        run_load(1);

        // Randomized images
        for (int r = 0; r < 4; r++) begin
            for (int unsigned i = 0; i < DEPTH; i++) img[i] = $urandom;
            run_load($urandom_range(1, DEPTH));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
